// File: rtl/persona_dead_sprite_fetch.sv
// ---------------------------------------------------------------------------
// persona_dead_sprite_fetch
//
// Pixel-pipeline stage for person A's dead sprite. For every pixel it decides
// whether the pixel falls inside the sprite box and, if so, addresses the
// sprite ROM. It then emits the fetched 8-bit palette index once the ROM data
// is back. Index 0 is the transparent key. A life-state FSM (ALIVE, BLINK,
// DEAD) gates visibility, so the sprite appears only after a kill event.
//
// Build option:
//   SPRITE_BLINK_EN  defined   : kill enters BLINK. The sprite flashes for
//                                BLINK_FRAMES frames, with BLINK_PERIOD frames
//                                per half-phase, then settles in DEAD.
//                    undefined : no BLINK state and no blink counter. kill
//                                moves ALIVE -> DEAD on the next cycle.
//
// Ports:
//   Clk            in   pixel clock
//   Reset          in   synchronous, active-high reset
//   frame_tick     in   one-cycle pulse per frame (start of vertical blank)
//   DrawX, DrawY   in   current pixel coordinates (10 bits each)
//   PosX, PosY     in   sprite top-left corner, latched on frame_tick
//   kill, revive   in   one-cycle life events
//   rom_addr       out  sprite ROM address (registered)
//   rom_data       in   sprite ROM data, one-cycle read latency
//   palette_index  out  palette index, 0 when the pixel is not drawn
//   sprite_on      out  pixel is an opaque, visible dead-sprite pixel
//   life_state     out  00 ALIVE, 01 BLINK, 10 DEAD
//
// Pipeline: a pixel is presented in cycle 0. Its ROM address is registered
// at the end of cycle 0. The ROM returns data during cycle 2, and
// palette_index/sprite_on are registered from that data.
// ---------------------------------------------------------------------------
module persona_dead_sprite_fetch #(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int ROM_AW = 10
`ifdef SPRITE_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PosX,
    input  logic [9:0]        PosY,
    input  logic              kill,
    input  logic              revive,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        palette_index,
    output logic              sprite_on,
    output logic [1:0]        life_state
);

    typedef enum logic [1:0] {
        ST_ALIVE = 2'b00,
        ST_BLINK = 2'b01,
        ST_DEAD  = 2'b10
    } life_t;

    life_t             state_r;
    logic [9:0]        pos_x_r;
    logic [9:0]        pos_y_r;

    logic [10:0]       draw_x_s;
    logic [10:0]       draw_y_s;
    logic [10:0]       pos_x_s;
    logic [10:0]       pos_y_s;
    logic [10:0]       off_x_s;
    logic [10:0]       off_y_s;
    logic              hit_s;
    logic              vis_s;
    logic [ROM_AW-1:0] rom_addr_s;
    logic              opaque_s;

    logic [ROM_AW-1:0] rom_addr_r;
    logic              hit_p1_r;
    logic              vis_p1_r;
    logic              hit_p2_r;
    logic              vis_p2_r;
    logic [7:0]        palette_index_r;
    logic              sprite_on_r;

`ifdef SPRITE_BLINK_EN
    localparam int CNT_W  = $clog2(BLINK_FRAMES + 1);
    localparam int PER_SH = $clog2(BLINK_PERIOD);
    logic [CNT_W-1:0]  blink_cnt_r;
`endif

    // Latch the sprite position once per frame so the sprite cannot tear mid-frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x_r <= 10'd0;
            pos_y_r <= 10'd0;
        end else if (frame_tick) begin
            pos_x_r <= PosX;
            pos_y_r <= PosY;
        end
    end

    // Hit test in 11 bits, so a box near the right or bottom edge cannot wrap.
    assign draw_x_s = {1'b0, DrawX};
    assign draw_y_s = {1'b0, DrawY};
    assign pos_x_s  = {1'b0, pos_x_r};
    assign pos_y_s  = {1'b0, pos_y_r};
    assign off_x_s  = draw_x_s - pos_x_s;
    assign off_y_s  = draw_y_s - pos_y_s;
    assign hit_s    = (draw_x_s >= pos_x_s) && (draw_x_s < (pos_x_s + 11'(SPR_W))) &&
                      (draw_y_s >= pos_y_s) && (draw_y_s < (pos_y_s + 11'(SPR_H)));

    // Row-major ROM address of the in-box offset; address 0 outside the box.
    always_comb begin
        rom_addr_s = {ROM_AW{1'b0}};
        if (hit_s) begin
            rom_addr_s = (ROM_AW'(off_y_s) * ROM_AW'(SPR_W)) + ROM_AW'(off_x_s);
        end else begin
            rom_addr_s = {ROM_AW{1'b0}};
        end
    end

    // Visibility derived from the current life state; it applies to the pixel entering now.
    always_comb begin
        vis_s = 1'b0;
        case (state_r)
            ST_ALIVE: vis_s = 1'b0;
`ifdef SPRITE_BLINK_EN
            // Visible on even half-phases of the blink counter.
            ST_BLINK: vis_s = ((32'(blink_cnt_r) >> PER_SH) & 32'd1) == 32'd0;
`endif
            ST_DEAD:  vis_s = 1'b1;
            default:  vis_s = 1'b0;
        endcase
    end

    // Life-state FSM. Each state only listens to its own event, which settles simultaneous kill/revive.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_ALIVE;
`ifdef SPRITE_BLINK_EN
            blink_cnt_r <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_ALIVE: begin
                    if (kill) begin
`ifdef SPRITE_BLINK_EN
                        // A frame_tick in the same cycle is not counted.
                        state_r     <= ST_BLINK;
                        blink_cnt_r <= {CNT_W{1'b0}};
`else
                        state_r     <= ST_DEAD;
`endif
                    end
                end
`ifdef SPRITE_BLINK_EN
                ST_BLINK: begin
                    if (frame_tick) begin
                        if (blink_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
                            state_r <= ST_DEAD;
                        end else begin
                            blink_cnt_r <= blink_cnt_r + CNT_W'(1);
                        end
                    end
                end
`endif
                ST_DEAD: begin
                    if (revive) begin
                        state_r <= ST_ALIVE;
                    end
                end
                default: state_r <= ST_ALIVE;
            endcase
        end
    end

    // The flags are delayed by two stages so that they line up with rom_data.
    assign opaque_s = hit_p2_r && vis_p2_r && (rom_data != 8'h00);

    // Address register, flag pipeline and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_r      <= {ROM_AW{1'b0}};
            hit_p1_r        <= 1'b0;
            vis_p1_r        <= 1'b0;
            hit_p2_r        <= 1'b0;
            vis_p2_r        <= 1'b0;
            palette_index_r <= 8'h00;
            sprite_on_r     <= 1'b0;
        end else begin
            rom_addr_r      <= rom_addr_s;
            hit_p1_r        <= hit_s;
            vis_p1_r        <= vis_s;
            hit_p2_r        <= hit_p1_r;
            vis_p2_r        <= vis_p1_r;
            palette_index_r <= opaque_s ? rom_data : 8'h00;
            sprite_on_r     <= opaque_s;
        end
    end

    assign rom_addr      = rom_addr_r;
    assign palette_index = palette_index_r;
    assign sprite_on     = sprite_on_r;
    assign life_state    = state_r;

endmodule
